// File: rtl/triumph_pkg.sv
// Shared constants and types for the Triumph register-file writeback controller.
package triumph_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREG_DEF   = 2 ** ADDR_W_DEF;

    // Round-robin pointer: which writeback producer wins a simultaneous request.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/triumph_wb_rr_arb.sv
// Two-way round-robin arbiter for the register-file write port.
// Side A is the ALU, side B is the load unit. After any grant the pointer
// favours the side that was not granted, so continuous dual requests alternate.
module triumph_wb_rr_arb
    import triumph_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    rr_ptr_e rr;
    rr_ptr_e rr_next;

    // Pointer register; reset favours the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= RR_ALU;
        end else begin
            rr <= rr_next;
        end
    end

    // Grant decision and pointer update from the current requests.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        rr_next = rr;
        if (req_a && (!req_b || rr == RR_ALU)) begin
            gnt_a = 1'b1;
        end else if (req_b) begin
            gnt_b = 1'b1;
        end
        if (gnt_a) begin
            rr_next = RR_LSU;
        end else if (gnt_b) begin
            rr_next = RR_ALU;
        end
    end

endmodule

// File: rtl/triumph_rf_wb_ctrl.sv
// Register-file write-port controller and hazard scoreboard for the Triumph core.
// Arbitrates ALU and load writebacks onto the single RF write port, registers the
// winning write, and tracks pending destinations so dependent issues stall.
// Optional feature macro: TRIUMPH_WB_BYPASS_EN -- lets sources and WAW targets that
// match the in-flight registered write proceed, with fwd_rs*_o steering ID to rf_wdata_o.
module triumph_rf_wb_ctrl
    import triumph_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    input  logic [ADDR_W-1:0]       issue_rs1_i,
    input  logic [ADDR_W-1:0]       issue_rs2_i,
    input  logic [ADDR_W-1:0]       issue_rd_i,
    input  logic                    issue_rd_we_i,
    output logic                    stall_o,
    input  logic                    alu_valid_i,
    input  logic [ADDR_W-1:0]       alu_rd_i,
    input  logic [DATA_W-1:0]       alu_data_i,
    output logic                    alu_ready_o,
    input  logic                    lsu_valid_i,
    input  logic [ADDR_W-1:0]       lsu_rd_i,
    input  logic [DATA_W-1:0]       lsu_data_i,
    output logic                    lsu_ready_o,
    output logic                    rf_we_o,
    output logic [ADDR_W-1:0]       rf_waddr_o,
    output logic [DATA_W-1:0]       rf_wdata_o,
    output logic                    fwd_rs1_o,
    output logic                    fwd_rs2_o,
    output logic [(2**ADDR_W)-1:0]  pending_o
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_next;
    logic [NREG-1:0]   clr_vec;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   pend_eff;
    logic              alu_gnt;
    logic              lsu_gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;
    logic              haz_rs1;
    logic              haz_rs2;
    logic              haz_rd;
    logic              issue_accept;

    triumph_wb_rr_arb u_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .req_a (alu_valid_i),
        .req_b (lsu_valid_i),
        .gnt_a (alu_gnt),
        .gnt_b (lsu_gnt)
    );

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;
    assign any_gnt     = alu_gnt | lsu_gnt;
    assign win_rd      = alu_gnt ? alu_rd_i   : lsu_rd_i;
    assign win_data    = alu_gnt ? alu_data_i : lsu_data_i;

    // Register being written this cycle; its pending bit clears at the edge.
    always_comb begin
        clr_vec = '0;
        if (rf_we_o) begin
            clr_vec[rf_waddr_o] = 1'b1;
        end
    end

`ifdef TRIUMPH_WB_BYPASS_EN
    // The clearing register no longer blocks: its value is on rf_wdata_o now.
    assign pend_eff  = pend & ~clr_vec;
    assign fwd_rs1_o = rf_we_o && (rf_waddr_o != '0) && (issue_rs1_i == rf_waddr_o);
    assign fwd_rs2_o = rf_we_o && (rf_waddr_o != '0) && (issue_rs2_i == rf_waddr_o);
`else
    assign pend_eff  = pend;
    assign fwd_rs1_o = 1'b0;
    assign fwd_rs2_o = 1'b0;
`endif

    assign haz_rs1      = (issue_rs1_i != '0) && pend_eff[issue_rs1_i];
    assign haz_rs2      = (issue_rs2_i != '0) && pend_eff[issue_rs2_i];
    assign haz_rd       = issue_rd_we_i && (issue_rd_i != '0) && pend_eff[issue_rd_i];
    assign stall_o      = issue_valid_i && (haz_rs1 || haz_rs2 || haz_rd);
    assign issue_accept = issue_valid_i && !stall_o;

    // Destination claimed by an accepted issue; x0 is never tracked.
    always_comb begin
        set_vec = '0;
        if (issue_accept && issue_rd_we_i && (issue_rd_i != '0)) begin
            set_vec[issue_rd_i] = 1'b1;
        end
    end

    // Set is applied after clear so a same-edge set of the clearing register wins.
    assign pend_next = ((pend & ~clr_vec) | set_vec) & {{(NREG-1){1'b1}}, 1'b0};
    assign pending_o = pend;

    // Scoreboard state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Registered RF write: capture the granted request, drop writes to x0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (any_gnt) begin
            rf_we_o    <= (win_rd != '0);
            rf_waddr_o <= win_rd;
            rf_wdata_o <= win_data;
        end else begin
            rf_we_o    <= 1'b0;
        end
    end

endmodule

// File: doc/triumph_rf_wb_ctrl.md
# triumph_rf_wb_ctrl

Register-file write-port controller and hazard scoreboard for the Triumph core. Sits between the issue (ID) stage, the two writeback producers (ALU/EX and load unit), and the single write port of the flop-based register file. Arbitrates the write port round-robin, registers the winning write, and tracks pending destinations so dependent instructions stall until their operands are written.

## Interface
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register address width; 2**ADDR_W registers, x0 hardwired zero.
- `clk_i  in  1`: clock; one clock; all state updates on the rising edge.
- `rst_i  in  1`: reset; synchronous, active-high.
- `issue_valid_i  in  1`: ID stage presents an instruction.
- `issue_rs1_i`, `issue_rs2_i  in  ADDR_W`: source addresses.
- `issue_rd_i  in  ADDR_W`: destination address.
- `issue_rd_we_i  in  1`: instruction writes rd.
- `stall_o  out  1`: hazard; ID must hold the instruction.
- `alu_valid_i  in  1`, `alu_rd_i  in  ADDR_W`, `alu_data_i  in  DATA_W`: ALU writeback request.
- `alu_ready_o  out  1`: ALU request granted this cycle.
- `lsu_valid_i  in  1`, `lsu_rd_i  in  ADDR_W`, `lsu_data_i  in  DATA_W`: load writeback request.
- `lsu_ready_o  out  1`: load request granted this cycle.
- `rf_we_o  out  1`, `rf_waddr_o  out  ADDR_W`, `rf_wdata_o  out  DATA_W`: registered write to the register file.
- `fwd_rs1_o`, `fwd_rs2_o  out  1`: source satisfied by the in-flight write (see Configuration).
- `pending_o  out  2**ADDR_W`: scoreboard bit vector, for debug.

## Operation
- Scoreboard `pend[r]`, one bit per register; bit 0 is always 0.
- Hazard: `stall_o` = issue_valid_i AND (rs1≠0 AND pend[rs1] OR rs2≠0 AND pend[rs2] OR issue_rd_we_i AND rd≠0 AND pend[rd]). WAW stalls, so at most one write per register is ever outstanding.
- Issue accept = issue_valid_i AND NOT stall_o; if issue_rd_we_i and rd≠0, set pend[rd] at the edge.
- Arbiter: one-bit pointer `rr` (0 = ALU favoured). Only ALU valid → ALU granted; only LSU valid → LSU granted; both valid → favoured side granted. After any grant, `rr` points at the non-granted side. Ready is combinational from the valids and `rr`; handshake = valid AND ready. The loser holds valid/rd/data stable.
- Grant registers {we = (rd≠0), waddr, wdata} into the rf_* outputs; no grant → rf_we_o = 0 next cycle, waddr/wdata hold.
- Clear: while rf_we_o = 1, pend[rf_waddr_o] clears at the end of that cycle. Set and clear of the same register at the same edge → set wins.
- A write to rd = 0 is accepted (handshake completes) but rf_we_o stays 0.
- Reset: pend = 0, rr = 0, rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0. An in-flight registered write is dropped. Combinational outputs follow from the cleared state: stall_o = 0 unless ID presents a hazard against cleared pend (none), fwd_* = 0.

## Timing
- Grant-to-write latency 1 cycle: handshake in cycle N → rf_we_o in cycle N+1 → register file holds the data from N+2.
- Without bypass, a dependent instruction stalls through cycle N+1 and issues in N+2 at the earliest.
- stall_o, alu_ready_o, lsu_ready_o, fwd_* are combinational (same cycle); all other outputs are registered.
- Throughput: one write per cycle. Under continuous dual requests, grants strictly alternate.

## Configuration
- `TRIUMPH_WB_BYPASS_EN` defined:
  - A source matching rf_waddr_o (≠0) while rf_we_o = 1 does not stall.
  - fwd_rs1_o / fwd_rs2_o assert for the matching sources; ID muxes in rf_wdata_o.
  - A WAW match on a clearing register does not stall either.
  - A dependent instruction issues in cycle N+1.
- Undefined: fwd_* are tied 0 and all pending sources stall until pend clears.

## Structure
- `triumph_pkg`: ADDR_W/DATA_W defaults, the register-count constant, and the enum for the arbiter pointer (RR_ALU, RR_LSU).
- One sub-module, `triumph_wb_rr_arb`: 2-way round-robin arbiter (valids in, grants out, pointer state).
- Scoreboard, hazard logic and output register live in the top.

## Test plan
- Issue `addi x5` (rd_we=1) → pend[5] = 1. Next instr rs1 = 5 → stall_o = 1. ALU writes x5 = 0x1234 → rf_we_o = 1, waddr = 5 one cycle later. Stall drops the cycle after that (non-bypass) or in the rf_we_o cycle (bypass, fwd_rs1_o = 1).
- ALU and LSU both valid for 4 cycles after reset → grants ALU, LSU, ALU, LSU; rf_waddr_o follows the granted rd with 1-cycle lag.
- LSU writes x0 with data 0xFFFF_FFFF → lsu_ready_o = 1, rf_we_o stays 0, pend unchanged.
- pend[7] = 1, issue new write to x7 → stall_o = 1 (WAW). In bypass build, issue in the rf_we_o cycle for x7 → accepted, pend[7] remains 1 (set wins).
- Assert rst_i while rf_we_o = 1 and pend = 0x0000_00A0 → next cycle pend = 0, rf_we_o = 0, rr = ALU.
- rs1 = rs2 = 0 with pend all ones except bit 0 → stall_o = 0.
